// File: rtl/enc_pkg.sv
// Shared types and code constants for the priority-encoder event path.
package enc_pkg;

  localparam int CODE_W = 2;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_I0 = 2'd0;
  localparam code_t CODE_I1 = 2'd1;
  localparam code_t CODE_I2 = 2'd2;
  localparam code_t CODE_I3 = 2'd3;

endpackage

// File: rtl/enc_change_det.sv
// Converts the encoder's level outputs into one-cycle events on a rising
// valid or a code change while valid.
module enc_change_det
  import enc_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  code_t code_in,
  input  logic  valid_in,
  output logic  evt
);

  logic  valid_q;
  code_t code_q;

  // Previous-cycle copy of the encoder outputs; rst and clr both forget history
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid_q <= 1'b0;
      code_q  <= CODE_I0;
    end else begin
      valid_q <= valid_in;
      code_q  <= code_in;
    end
  end

  assign evt = valid_in & (~valid_q | (code_in != code_q));

endmodule

// File: rtl/enc_event_fifo.sv
// Event FIFO behind the 4-to-2 priority encoder: first-word-fall-through
// buffer with valid/ready drain and a sticky overflow / saturating drop count.
module enc_event_fifo
  import enc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  code_t                  code_in,
  input  logic                   valid_in,
  input  logic                   clr,
  output code_t                  out_code,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   ovf,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [CNT_W-1:0] SAT_C   = {CNT_W{1'b1}};

  code_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic evt;
  logic empty;
  logic pop;
  logic push_ok;
  logic drop;

  enc_change_det u_change_det (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .code_in  (code_in),
    .valid_in (valid_in),
    .evt      (evt)
  );

  assign empty   = (count_q == {CW{1'b0}});
  assign full    = (count_q == DEPTH_C);
  assign pop     = ~empty & out_ready;
  // A pop frees the slot in the same edge, so a full FIFO still accepts.
  assign push_ok = evt & (~full | pop);
  assign drop    = evt & full & ~pop;

  // Next-state for pointers, occupancy and overflow bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != SAT_C) begin
        drop_d = drop_q + CNT_W'(1);
      end else begin
        drop_d = drop_q;
      end
    end else begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
    end
  end

  // Control state; rst and clr both return to empty with history cleared
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CW{1'b0}};
      ovf_q    <= 1'b0;
      drop_q   <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage; contents are don't-care while not covered by count
  always_ff @(posedge clk) begin
    if (push_ok && !rst && !clr) begin
      mem_q[wr_ptr_q] <= code_in;
    end
  end

  assign out_valid = ~empty;
  assign out_code  = empty ? CODE_I0 : mem_q[rd_ptr_q];
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_enc_event_fifo.sv
// Directed self-checking bench for enc_event_fifo with hand-computed expectations.
module tb_enc_event_fifo;
  import enc_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             clr;
  code_t            code_in;
  logic             valid_in;
  code_t            out_code;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       count;
  logic             full;
  logic             ovf;
  logic [CNT_W-1:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  enc_event_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .code_in   (code_in),
    .valid_in  (valid_in),
    .clr       (clr),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one edge, then settle so outputs are sampled away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input code_t c, input logic v, input logic r);
    code_in   = c;
    valid_in  = v;
    out_ready = r;
    tick();
  endtask

  task automatic flush();
    valid_in  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic check_state(input string tag, input int c, input int v, input int oc,
                             input int f, input int o, input int d);
    check_eq({tag, "_count"}, int'(count), c);
    check_eq({tag, "_valid"}, int'(out_valid), v);
    check_eq({tag, "_code"}, int'(out_code), oc);
    check_eq({tag, "_full"}, int'(full), f);
    check_eq({tag, "_ovf"}, int'(ovf), o);
    check_eq({tag, "_drop"}, int'(drop_cnt), d);
  endtask

  // count=3, ovf=1, drop_cnt=1, change detector holding valid code 0
  task automatic setup_mid();
    flush();
    drive(CODE_I0, 1'b1, 1'b0);
    drive(CODE_I1, 1'b1, 1'b0);
    drive(CODE_I2, 1'b1, 1'b0);
    drive(CODE_I3, 1'b1, 1'b0);
    drive(CODE_I0, 1'b1, 1'b0);
    drive(CODE_I0, 1'b1, 1'b1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; code_in = CODE_I0; valid_in = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_state("reset", 0, 0, 0, 0, 0, 0);

    // 1: steady valid code yields exactly one entry, visible the next cycle
    drive(CODE_I2, 1'b1, 1'b0);
    check_state("single_first", 1, 1, 2, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(CODE_I2, 1'b1, 1'b0);
    check_state("single_hold", 1, 1, 2, 0, 0, 0);

    // 2: four changes fill the FIFO, drained in order
    flush();
    drive(CODE_I0, 1'b1, 1'b0);
    drive(CODE_I1, 1'b1, 1'b0);
    drive(CODE_I2, 1'b1, 1'b0);
    drive(CODE_I3, 1'b1, 1'b0);
    check_state("seq_full", 4, 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("seq_pop_code", int'(out_code), i);
      drive(CODE_I3, 1'b1, 1'b1);
    end
    check_state("seq_drained", 0, 0, 0, 0, 0, 0);

    // 3: overflow drops three events, contents preserved
    drive(CODE_I0, 1'b1, 1'b0);
    drive(CODE_I1, 1'b1, 1'b0);
    drive(CODE_I2, 1'b1, 1'b0);
    drive(CODE_I3, 1'b1, 1'b0);
    drive(CODE_I0, 1'b1, 1'b0);
    drive(CODE_I1, 1'b1, 1'b0);
    drive(CODE_I2, 1'b1, 1'b0);
    check_state("ovf", 4, 1, 0, 1, 1, 3);
    for (int i = 0; i < 4; i++) begin
      check_eq("ovf_pop_code", int'(out_code), i);
      drive(CODE_I2, 1'b1, 1'b1);
    end
    check_state("ovf_drained", 0, 0, 0, 0, 1, 3);

    // 4: event while full with a simultaneous pop is accepted
    flush();
    drive(CODE_I0, 1'b1, 1'b0);
    drive(CODE_I1, 1'b1, 1'b0);
    drive(CODE_I2, 1'b1, 1'b0);
    drive(CODE_I0, 1'b1, 1'b0);
    drive(CODE_I3, 1'b1, 1'b1);
    check_state("fullpop", 4, 1, 1, 1, 0, 0);
    begin
      int exp_q [4] = '{1, 2, 0, 3};
      for (int i = 0; i < 4; i++) begin
        check_eq("fullpop_drain", int'(out_code), exp_q[i]);
        drive(CODE_I3, 1'b1, 1'b1);
      end
    end
    check_state("fullpop_empty", 0, 0, 0, 0, 0, 0);
    drive(CODE_I3, 1'b1, 1'b1);
    check_eq("ready_empty_count", int'(count), 0);

    // 5: valid toggling gives one event per rise; idle gives none
    flush();
    drive(CODE_I1, 1'b1, 1'b0);
    drive(CODE_I1, 1'b0, 1'b0);
    drive(CODE_I1, 1'b1, 1'b0);
    check_state("toggle", 2, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(CODE_I1, 1'b0, 1'b0);
    check_state("toggle_idle", 2, 1, 1, 0, 0, 0);

    // 6: clr with a coincident event discards it and clears everything
    setup_mid();
    check_state("mid_clr_pre", 3, 1, 1, 0, 1, 1);
    code_in = CODE_I1; valid_in = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; valid_in = 1'b0;
    check_state("mid_clr", 0, 0, 0, 0, 0, 0);
    tick();
    check_eq("mid_clr_after", int'(count), 0);

    setup_mid();
    check_state("mid_rst_pre", 3, 1, 1, 0, 1, 1);
    code_in = CODE_I1; valid_in = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; valid_in = 1'b0;
    check_state("mid_rst", 0, 0, 0, 0, 0, 0);
    tick();
    check_eq("mid_rst_after", int'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
